lcd_text_driver: RTL and testbench

//  Downstream of the parameter-entry FSM: takes its 32-char lcd_text bus and drives the 16x2 HD44780 character LCD.

---
 rtl/lcd_text_driver_if.sv | 34 +++
 rtl/lcd_text_driver.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_lcd_text_driver.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_driver_if.sv
// lcd_text_driver_if: the HD44780 panel pins driven by lcd_text_driver.
//   lcd_data  DB7..DB0
//   lcd_rs    0 = command, 1 = data
//   lcd_rw    write/read select (held at write)
//   lcd_en    enable strobe
//   lcd_on    panel power
//   lcd_blon  backlight
// The master modport belongs to the driver and the slave modport to the panel side.
interface lcd_text_driver_if;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic       lcd_on;
    logic       lcd_blon;

    modport master (
        output lcd_data,
        output lcd_rs,
        output lcd_rw,
        output lcd_en,
        output lcd_on,
        output lcd_blon
    );

    modport slave (
        input lcd_data,
        input lcd_rs,
        input lcd_rw,
        input lcd_en,
        input lcd_on,
        input lcd_blon
    );
endinterface

// File: rtl/lcd_text_driver.sv
// lcd_text_driver: runs the HD44780 power-up init and then rewrites both
// 16-char lines of a 16x2 LCD whenever the 32-char text bus changes.
// Leading 0x00 bytes, which come from right-justified string literals, are
// stripped so the text is left-justified, and the tail is padded with spaces.
// Ports:
//   clock         system clock
//   reset         asynchronous, active-low reset
//   text          32 ASCII chars, char i = text[255-8*i -: 8]
//   lcd           panel pins (lcd_text_driver_if.master)
//   busy          high in every state except IDLE
//   refresh_done  one-cycle pulse after the last char of a refresh has finished its wait
module lcd_text_driver #(
    parameter int unsigned POWERUP_CYCLES = 750000,
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned EN_CYCLES      = 12,
    parameter int unsigned CMD_CYCLES     = 2000,
    parameter int unsigned CLEAR_CYCLES   = 82000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [255:0]        text,
    lcd_text_driver_if.master   lcd,
    output logic                busy,
    output logic                refresh_done
);

    localparam int unsigned MAX_A   = (POWERUP_CYCLES > CLEAR_CYCLES) ? POWERUP_CYCLES : CLEAR_CYCLES;
    localparam int unsigned MAX_B   = (CMD_CYCLES > EN_CYCLES) ? CMD_CYCLES : EN_CYCLES;
    localparam int unsigned MAX_C   = (MAX_B > SETUP_CYCLES) ? MAX_B : SETUP_CYCLES;
    localparam int unsigned MAX_DLY = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int unsigned CW      = $clog2(MAX_DLY) + 1;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_LINE1 = 8'h80;
    localparam logic [7:0] CMD_LINE2 = 8'hC0;
    localparam logic [7:0] CHR_SPACE = 8'h20;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT,
        ST_IDLE,
        ST_ADDR1,
        ST_LINE1,
        ST_ADDR2,
        ST_LINE2,
        ST_DONE
    } state_e;

    // Phases of the single-byte transfer shared by every command and char.
    typedef enum logic [1:0] {
        PH_NONE,
        PH_SETUP,
        PH_EN,
        PH_WAIT
    } phase_e;

    state_e         state_q, state_d;
    phase_e         phase_q, phase_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     idx_q, idx_d;
    logic [4:0]     pos_q, pos_d;
    logic [5:0]     lead_q, lead_d;
    logic [255:0]   snap_q, snap_d;
    logic [255:0]   shadow_q, shadow_d;
    logic [7:0]     data_q, data_d;
    logic           rs_q, rs_d;
    logic           en_q, en_d;
    logic           on_q, on_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           byte_done;
    logic           issue;
    logic [7:0]     issue_data;
    logic           issue_rs;

    // Init command list, sent in index order.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] c;
        case (idx)
            2'd0:    c = 8'h38;
            2'd1:    c = 8'h0C;
            2'd2:    c = CMD_CLEAR;
            default: c = 8'h06;
        endcase
        return c;
    endfunction

    // Number of leading 0x00 chars (0..32).
    function automatic logic [5:0] count_lead(input logic [255:0] t);
        logic [5:0] n;
        logic       stop;
        n    = '0;
        stop = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (!stop && (t[255-8*i -: 8] == 8'h00)) begin
                n = n + 6'd1;
            end else begin
                stop = 1'b1;
            end
        end
        return n;
    endfunction

    // Char for display position pos: snap char lead+pos, space past the end or for a null.
    function automatic logic [7:0] disp_char(input logic [255:0] s, input logic [5:0] lead,
                                             input logic [4:0] pos);
        logic [6:0] sum;
        logic [7:0] c;
        sum = 7'(lead) + 7'(pos);
        c   = CHR_SPACE;
        for (int i = 0; i < 32; i++) begin
            if (sum == 7'(i)) begin
                c = s[255-8*i -: 8];
            end
        end
        if (c == 8'h00) begin
            c = CHR_SPACE;
        end
        return c;
    endfunction

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_POWERUP;
            phase_q  <= PH_NONE;
            cnt_q    <= CW'(POWERUP_CYCLES - 1);
            idx_q    <= '0;
            pos_q    <= '0;
            lead_q   <= '0;
            snap_q   <= '0;
            shadow_q <= '1;
            data_q   <= '0;
            rs_q     <= 1'b0;
            en_q     <= 1'b0;
            on_q     <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pos_q    <= pos_d;
            lead_q   <= lead_d;
            snap_q   <= snap_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            rs_q     <= rs_d;
            en_q     <= en_d;
            on_q     <= on_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Byte-transfer sequencing, then the refresh FSM that chooses the next byte.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        pos_d      = pos_q;
        lead_d     = lead_q;
        snap_d     = snap_q;
        shadow_d   = shadow_q;
        data_d     = data_q;
        rs_d       = rs_q;
        en_d       = en_q;
        on_d       = 1'b1;
        done_d     = 1'b0;
        busy_d     = busy_q;
        byte_done  = 1'b0;
        issue      = 1'b0;
        issue_data = '0;
        issue_rs   = 1'b0;

        case (phase_q)
            PH_SETUP: begin
                if (cnt_q == '0) begin
                    en_d    = 1'b1;
                    phase_d = PH_EN;
                    cnt_d   = CW'(EN_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            PH_EN: begin
                if (cnt_q == '0) begin
                    en_d    = 1'b0;
                    phase_d = PH_WAIT;
                    // Clear-display needs the long wait; everything else the normal one.
                    cnt_d   = (!rs_q && (data_q == CMD_CLEAR)) ? CW'(CLEAR_CYCLES - 1)
                                                               : CW'(CMD_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            PH_WAIT: begin
                if (cnt_q == '0) begin
                    byte_done = 1'b1;
                    phase_d   = PH_NONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: ;
        endcase

        case (state_q)
            ST_POWERUP: begin
                if (cnt_q == '0) begin
                    state_d    = ST_INIT;
                    idx_d      = '0;
                    issue      = 1'b1;
                    issue_data = init_cmd(2'd0);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_INIT: begin
                if (byte_done) begin
                    if (idx_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        issue      = 1'b1;
                        issue_data = init_cmd(idx_q + 2'd1);
                    end
                end
            end
            ST_IDLE: begin
                if (text != shadow_q) begin
                    snap_d     = text;
                    shadow_d   = text;
                    lead_d     = count_lead(text);
                    state_d    = ST_ADDR1;
                    issue      = 1'b1;
                    issue_data = CMD_LINE1;
                end
            end
            ST_ADDR1: begin
                if (byte_done) begin
                    state_d    = ST_LINE1;
                    pos_d      = 5'd0;
                    issue      = 1'b1;
                    issue_rs   = 1'b1;
                    issue_data = disp_char(snap_q, lead_q, 5'd0);
                end
            end
            ST_LINE1: begin
                if (byte_done) begin
                    if (pos_q == 5'd15) begin
                        state_d    = ST_ADDR2;
                        issue      = 1'b1;
                        issue_data = CMD_LINE2;
                    end else begin
                        pos_d      = pos_q + 5'd1;
                        issue      = 1'b1;
                        issue_rs   = 1'b1;
                        issue_data = disp_char(snap_q, lead_q, pos_q + 5'd1);
                    end
                end
            end
            ST_ADDR2: begin
                if (byte_done) begin
                    state_d    = ST_LINE2;
                    pos_d      = 5'd16;
                    issue      = 1'b1;
                    issue_rs   = 1'b1;
                    issue_data = disp_char(snap_q, lead_q, 5'd16);
                end
            end
            ST_LINE2: begin
                if (byte_done) begin
                    if (pos_q == 5'd31) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        pos_d      = pos_q + 5'd1;
                        issue      = 1'b1;
                        issue_rs   = 1'b1;
                        issue_data = disp_char(snap_q, lead_q, pos_q + 5'd1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_POWERUP;
            end
        endcase

        // A new byte starts its setup phase; rs/data are held until it is done.
        if (issue) begin
            data_d  = issue_data;
            rs_d    = issue_rs;
            phase_d = PH_SETUP;
            cnt_d   = CW'(SETUP_CYCLES - 1);
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign lcd.lcd_data  = data_q;
    assign lcd.lcd_rs    = rs_q;
    assign lcd.lcd_rw    = 1'b0;
    assign lcd.lcd_en    = en_q;
    assign lcd.lcd_on    = on_q;
    assign lcd.lcd_blon  = on_q;
    assign busy          = busy_q;
    assign refresh_done  = done_q;

endmodule

// File: tb/tb_lcd_text_driver.sv
// tb_lcd_text_driver: drives text patterns into lcd_text_driver, records every
// en strobe as {rs,data} and compares against a reference byte stream built
// from the display rules (strip leading nulls, pad with spaces, nulls -> space).
module tb_lcd_text_driver;

    localparam int unsigned POWERUP = 20;
    localparam int unsigned SETUP   = 1;
    localparam int unsigned EN      = 2;
    localparam int unsigned CMD     = 5;
    localparam int unsigned CLEAR   = 10;
    localparam int          BUDGET  = 3000;

    logic         clk;
    logic         rst_n;
    logic [255:0] text;
    logic         busy;
    logic         refresh_done;

    lcd_text_driver_if lcd_if ();

    lcd_text_driver #(
        .POWERUP_CYCLES (POWERUP),
        .SETUP_CYCLES   (SETUP),
        .EN_CYCLES      (EN),
        .CMD_CYCLES     (CMD),
        .CLEAR_CYCLES   (CLEAR)
    ) dut (
        .clock        (clk),
        .reset        (rst_n),
        .text         (text),
        .lcd          (lcd_if),
        .busy         (busy),
        .refresh_done (refresh_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Captured strobes and expected stream, each entry {rs, data}.
    logic [8:0] cap_q[$];
    int         rise_q[$];
    logic [8:0] exp_q[$];
    int         cyc = 0;
    int         done_cnt = 0;
    int         rise_cyc = 0;
    logic       en_prev = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            en_prev = 1'b0;
        end else begin
            if (lcd_if.lcd_en && !en_prev) begin
                cap_q.push_back({lcd_if.lcd_rs, lcd_if.lcd_data});
                rise_q.push_back(cyc);
                rise_cyc = cyc;
                check("rw_low", 32'(lcd_if.lcd_rw), 32'd0);
            end
            if (!lcd_if.lcd_en && en_prev) begin
                check("en_width", 32'(cyc - rise_cyc), 32'(EN));
            end
            if (refresh_done) done_cnt++;
            en_prev = lcd_if.lcd_en;
        end
    end

    // Reference model: init commands.
    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endtask

    // Reference model: one refresh of text t.
    task automatic push_refresh(input logic [255:0] t);
        logic [7:0] ch[32];
        logic [7:0] v;
        int         n;
        for (int i = 0; i < 32; i++) ch[i] = t[255-8*i -: 8];
        n = 0;
        while (n < 32 && ch[n] == 8'h00) n++;
        exp_q.push_back({1'b0, 8'h80});
        for (int k = 0; k < 32; k++) begin
            if (k == 16) exp_q.push_back({1'b0, 8'hC0});
            v = (n + k < 32) ? ch[n + k] : 8'h20;
            if (v == 8'h00) v = 8'h20;
            exp_q.push_back({1'b1, v});
        end
    endtask

    task automatic compare_stream(input string name);
        check({name, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_b%0d", name, i), 32'(cap_q[i]), 32'(exp_q[i]));
        end
        cap_q.delete();
        rise_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", 32'(done_cnt >= target), 32'd1);
        repeat (2) @(negedge clk);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic wait_caps(input int count);
        int n;
        n = 0;
        while (cap_q.size() < count && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("caps_reached", 32'(cap_q.size() >= count), 32'd1);
    endtask

    function automatic logic [255:0] random_text();
        logic [255:0] t;
        int           n;
        t = '0;
        n = $urandom_range(0, 32);
        for (int i = 0; i < 32; i++) begin
            if (i >= n) begin
                if ($urandom_range(0, 7) == 0) t[255-8*i -: 8] = 8'h00;
                else                           t[255-8*i -: 8] = 8'($urandom_range(33, 126));
            end
        end
        return t;
    endfunction

    task automatic run_text(input string name, input logic [255:0] t);
        int base;
        base = done_cnt;
        cap_q.delete();
        rise_q.delete();
        text = t;
        push_refresh(t);
        wait_done(base + 1);
        compare_stream(name);
    endtask

    initial begin
        logic [255:0] ta;
        logic [255:0] tb_t;
        int           base;
        int           n;

        rst_n = 1'b0;
        text  = '0;
        repeat (3) @(negedge clk);
        check("rst_en",    32'(lcd_if.lcd_en),   32'd0);
        check("rst_data",  32'(lcd_if.lcd_data), 32'd0);
        check("rst_rs",    32'(lcd_if.lcd_rs),   32'd0);
        check("rst_on",    32'(lcd_if.lcd_on),   32'd0);
        check("rst_blon",  32'(lcd_if.lcd_blon), 32'd0);
        check("rst_busy",  32'(busy),            32'd1);
        check("rst_done",  32'(refresh_done),    32'd0);

        // Power-up, init and first refresh of all-zero text.
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("on_after",   32'(lcd_if.lcd_on),   32'd1);
        check("blon_after", 32'(lcd_if.lcd_blon), 32'd1);
        push_init();
        push_refresh('0);
        wait_done(1);
        check("first_en_cycle", 32'(rise_q.size() > 0 && rise_q[0] >= int'(POWERUP)), 32'd1);
        check("clear_gap", 32'(rise_q.size() > 3 && (rise_q[3] - rise_q[2] - int'(EN)) >= int'(CLEAR)), 32'd1);
        compare_stream("init");

        // Directed patterns.
        run_text("short", 256'("Enter c_real."));
        run_text("full",  256'("ABCDEFGHIJKLMNOPabcdefghijklmnop"));
        run_text("null",  256'({"AB", 8'h00, "C"}));

        // Constant text: no traffic, stays idle.
        cap_q.delete();
        repeat (200) @(negedge clk);
        check("hold_no_en", 32'(cap_q.size()), 32'd0);
        check("hold_busy",  32'(busy),         32'd0);

        // Random texts.
        for (int r = 0; r < 6; r++) begin
            run_text($sformatf("rnd%0d", r), random_text());
        end

        // Text change during LINE1: old snapshot finishes, then a second refresh.
        ta   = random_text();
        tb_t = random_text();
        tb_t[7:0] = 8'h41;
        ta[7:0]   = 8'h42;
        base = done_cnt;
        cap_q.delete();
        rise_q.delete();
        text = ta;
        wait_caps(6);
        text = tb_t;
        push_refresh(ta);
        push_refresh(tb_t);
        wait_done(base + 2);
        repeat (300) @(negedge clk);
        check("two_pulses", 32'(done_cnt - base), 32'd2);
        compare_stream("change");

        // Reset while en is high during a char.
        text = 256'("reset me please!");
        cap_q.delete();
        n = 0;
        while (!(lcd_if.lcd_en && cap_q.size() >= 3) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("en_seen", 32'(lcd_if.lcd_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_en_drop", 32'(lcd_if.lcd_en), 32'd0);
        check("rst_busy2",   32'(busy),          32'd1);
        repeat (3) @(negedge clk);
        cap_q.delete();
        rise_q.delete();
        #1 rst_n = 1'b1;
        base = done_cnt;
        push_init();
        push_refresh(text);
        wait_done(base + 1);
        check("rerun_en_cycle", 32'(rise_q.size() > 0 && rise_q[0] >= int'(POWERUP)), 32'd1);
        compare_stream("rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
